// File: rtl/mcmem_resp.sv
// Word-addressed 32-bit memory with a fixed number of wait states per access,
// serving a multi-cycle CPU memory stage through a req/ready handshake.
module mcmem_resp #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt_p0;
  logic                we_p0;
  logic [31:0]         addr_p0;
  logic [31:0]         wdata_p0;
  logic                err_p1;
  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                commit;
  logic                acc_we;
  logic [31:0]         acc_addr;
  logic [31:0]         acc_wdata;
  logic                acc_bad;
  logic [ADDR_W-1:0]   acc_idx;

  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (ADDR_W + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  // With WAIT=0 the commit edge is the accepting edge, so the live inputs
  // stand in for the not-yet-captured registers.
  assign accept    = (state == ST_IDLE) && req;
  assign acc_we    = (state == ST_IDLE) ? we    : we_p0;
  assign acc_addr  = (state == ST_IDLE) ? addr  : addr_p0;
  assign acc_wdata = (state == ST_IDLE) ? wdata : wdata_p0;
  assign acc_bad   = addr_bad(acc_addr);
  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign commit    = (state_nxt == ST_RESP) && !reset;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) state_nxt = (WAIT > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt_p0 == 4'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        busy      = 1'b1;
        ready     = 1'b1;
        err       = err_p1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt_p0 <= 4'd0;
      err_p1 <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt_p0 <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt_p0 != 4'd0) begin
        cnt_p0 <= cnt_p0 - 4'd1;
      end
      if (commit) begin
        err_p1 <= acc_bad;
        if (!acc_bad && !acc_we) rdata <= mem[acc_idx];
      end
    end
  end

  // Capture stage: request fields frozen on the accepting edge
  always_ff @(posedge clock) begin
    if (accept) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // Array stage: never reset, written only by a valid committed store
  always_ff @(posedge clock) begin
    if (commit && acc_we && !acc_bad) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mcmem_resp.sv
// Directed bench for mcmem_resp: scoreboarded accesses on a WAIT=2 instance
// plus a zero-wait instance for the single-cycle response path.
module tb_mcmem_resp;

  localparam int WAIT_T = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, busy, err;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0, busy0, err0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  logic [31:0] m_rdata = 32'd0;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  mcmem_resp #(.ADDR_W(8), .WAIT(WAIT_T)) u_dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mcmem_resp #(.ADDR_W(8), .WAIT(0)) u_dut0 (
    .clock(clock), .reset(reset), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access on the WAIT_T instance, driven and checked at negedges.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    exp_t e;
    int   lat;
    e.err = (a[1:0] != 2'b00) || ((a >> 10) != 32'd0);
    if (!e.err) begin
      if (w) model[a[9:2]] = d;
      else   m_rdata = model[a[9:2]];
    end
    e.rdata = m_rdata;
    e.tag   = tag;
    sb.push_back(e);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clock);
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    lat = 1;
    while (ready !== 1'b1 && lat <= WAIT_T + 4) begin
      chk({tag, " busy_wait"}, 32'(busy), 32'd1);
      chk({tag, " err_wait"}, 32'(err), 32'd0);
      @(negedge clock);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(WAIT_T + 1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, " ready"}, 32'(ready), 32'd1);
      chk({e.tag, " err"}, 32'(err), 32'(e.err));
      chk({e.tag, " rdata"}, rdata, e.rdata);
    end else begin
      chk({tag, " sb_empty"}, 32'(sb.size()), 32'd1);
    end
    @(negedge clock);
    chk({tag, " ready_drop"}, 32'(ready), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tbl [4];
    exp_t        e;
    int          last_k;
    int          n_rdy;

    // Reset
    repeat (2) @(negedge clock);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst rdata0", rdata0, 32'd0);

    // Request coinciding with reset is dropped
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clock);
    chk("req_in_reset busy", 32'(busy), 32'd0);
    req = 1'b0; reset = 1'b0;
    @(negedge clock);
    chk("req_in_reset idle", 32'(busy), 32'd0);
    chk("req_in_reset ready", 32'(ready), 32'd0);

    // Write then read back
    access(1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    access(1'b0, 32'h10, 32'h0, "rd10");

    // Misaligned store is rejected and leaves the word intact
    access(1'b1, 32'h12, 32'h11111111, "wr12_mis");
    access(1'b0, 32'h10, 32'h0, "rd10_after_mis");

    // Out-of-range read keeps previous rdata
    access(1'b0, 32'h400, 32'h0, "rd400_oor");

    // Reset in the first wait cycle aborts a pending store
    access(1'b1, 32'h20, 32'hCAFEF00D, "wr20_old");
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clock);
    req = 1'b0;
    chk("abort in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_rdata = 32'd0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(ready), 32'd0);
    chk("abort rdata", rdata, 32'd0);
    n_rdy = 0;
    repeat (WAIT_T + 2) begin
      @(negedge clock);
      if (ready === 1'b1) n_rdy++;
    end
    chk("abort no_ready", 32'(n_rdy), 32'd0);
    access(1'b0, 32'h20, 32'h0, "rd20_after_abort");

    // Continuous req with a moving address: only IDLE-cycle addresses count
    tbl[0] = 32'h40; tbl[1] = 32'h44; tbl[2] = 32'h48; tbl[3] = 32'h4C;
    for (int i = 0; i < 4; i++) access(1'b1, tbl[i], 32'hA0B0_0000 + 32'(i * 7 + 3), "preload");
    req = 1'b1; we = 1'b0;
    last_k = -1;
    n_rdy = 0;
    for (int k = 0; k < 12; k++) begin
      addr = (k % (WAIT_T + 2) == 0) ? tbl[(k / (WAIT_T + 2)) % 4]
                                     : tbl[(k / (WAIT_T + 2) + 1) % 4];
      if (k % (WAIT_T + 2) == 0) begin
        m_rdata = model[addr[9:2]];
        e.err = 1'b0; e.rdata = m_rdata; e.tag = "held_req";
        sb.push_back(e);
      end
      @(negedge clock);
      if (ready === 1'b1) begin
        n_rdy++;
        if (last_k >= 0) chk("held_req spacing", 32'(k - last_k), 32'(WAIT_T + 2));
        last_k = k;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({e.tag, " err"}, 32'(err), 32'(e.err));
          chk({e.tag, " rdata"}, rdata, e.rdata);
        end
      end
    end
    req = 1'b0;
    chk("held_req count", 32'(n_rdy), 32'd3);
    chk("held_req sb_drained", 32'(sb.size()), 32'd0);
    repeat (WAIT_T + 3) @(negedge clock);

    // Zero-wait instance: response on the cycle after acceptance
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h5A5A0001;
    @(negedge clock);
    req0 = 1'b0; wdata0 = 32'h0;
    chk("w0 wr busy", 32'(busy0), 32'd1);
    chk("w0 wr ready", 32'(ready0), 32'd1);
    chk("w0 wr err", 32'(err0), 32'd0);
    @(negedge clock);
    chk("w0 wr idle", 32'(busy0), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    @(negedge clock);
    req0 = 1'b0; addr0 = 32'h8;
    chk("w0 rd busy", 32'(busy0), 32'd1);
    chk("w0 rd ready", 32'(ready0), 32'd1);
    chk("w0 rd rdata", rdata0, 32'h5A5A0001);
    @(negedge clock);
    chk("w0 rd idle", 32'(busy0), 32'd0);
    chk("w0 rd ready_drop", 32'(ready0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mcmem_resp.md
MCMEM_RESP -- requirements
Module: mcmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of the word depth (256 x 32-bit words).
REQ-002 SHALL have parameter WAIT, default 2, range 0..15, meaning the number of wait cycles inserted before each access completes.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 SHALL have port req, input, 1 bit: access request from the multi-cycle CPU memory stage.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr, input, 32 bits: byte address; qualified by req.
REQ-008 SHALL have port wdata, input, 32 bits: store data; qualified by req and we.
REQ-009 SHALL have port rdata, output, 32 bits: read data, valid while ready=1 for a read.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.
REQ-012 SHALL have port err, output, 1 bit: access rejected; valid only with ready.

Function
REQ-013 SHALL contain a 2^ADDR_W x 32 word array, indexed by addr[ADDR_W+1:2].
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP; encoding is free.
REQ-015 Transitions SHALL be as follows.
- IDLE: req=1 -> WAIT if WAIT>0, else RESP.
- IDLE: req=0 -> IDLE.
- WAIT: counter=0 -> RESP, else WAIT.
- RESP -> IDLE unconditionally.
REQ-016 On the accepting IDLE cycle, the block SHALL capture we, addr and wdata into internal registers and load a 4-bit wait counter with WAIT-1.
REQ-017 In WAIT, the counter SHALL decrement by 1 each cycle; it SHALL NOT wrap below 0.
REQ-018 Inputs SHALL be ignored when not in IDLE; changes to req, we, addr or wdata after acceptance SHALL NOT affect the access in progress.
REQ-019 Latency from the accepting edge to ready=1 SHALL be exactly WAIT+1 cycles; ready SHALL be high for exactly one cycle (RESP).
REQ-020 A new request SHALL be accepted no earlier than the cycle after RESP, so there is at least one IDLE cycle between accesses.
REQ-021 The access SHALL be rejected (err=1 in RESP) if either condition holds:
- the captured addr[1:0] != 0 (misaligned);
- the captured addr[31:ADDR_W+2] != 0 (out of range).
REQ-022 A rejected write SHALL NOT modify memory; a rejected read SHALL leave rdata unchanged.
REQ-023 A valid write SHALL update the addressed word on the rising edge that leaves the final wait cycle (entering RESP); err=0 in RESP.
REQ-024 A valid read SHALL load rdata from the array on the same edge, so the data is valid in the RESP cycle.
REQ-025 rdata SHALL hold its last loaded value until the next valid read; writes SHALL NOT change rdata.
REQ-026 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-027 err SHALL be 0 whenever ready=0.

Reset
REQ-028 On reset=1 at a rising edge, regardless of state, the block SHALL set state=IDLE, counter=0, ready=0, busy=0, err=0 and rdata=0.
REQ-029 A reset asserted during WAIT SHALL abort the access, and a pending write SHALL NOT be performed.
REQ-030 Memory array contents SHALL NOT be altered by reset.
REQ-031 If req=1 and reset=1 on the same edge, reset SHALL win and the request SHALL NOT be accepted.

Verification
REQ-032 Write then read, WAIT=2: write addr=0x10, wdata=0xDEADBEEF -> ready rises 3 cycles after acceptance with err=0. Then read addr=0x10 -> ready after 3 cycles with rdata=0xDEADBEEF.
REQ-033 WAIT=0: read addr=0x0 -> busy and ready both 1 on the cycle after acceptance; IDLE on the following cycle.
REQ-034 Misaligned write to addr=0x12, then read of addr=0x10 -> first access returns ready=1, err=1; second returns the prior value (0xDEADBEEF).
REQ-035 Out of range, ADDR_W=8: read addr=0x400 -> ready=1, err=1, rdata unchanged.
REQ-036 Reset during WAIT: write addr=0x20, wdata=0x12345678, reset pulsed in the first WAIT cycle -> no ready pulse; a later read of 0x20 returns the old contents.
REQ-037 Busy-time request: hold req=1 continuously with changing addr -> each access uses the addr captured in IDLE; ready pulses are spaced exactly WAIT+2 cycles apart.
